// File: rtl/dma_pkg.sv
// Shared constants for the DMA controller: CPU register indices and FSM state encoding.
package dma_pkg;

  localparam logic [1:0] REG_SRC_L = 2'd0;
  localparam logic [1:0] REG_SRC_U = 2'd1;
  localparam logic [1:0] REG_DST   = 2'd2;
  localparam logic [1:0] REG_AMT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/dma_controller.sv
// Single-channel word DMA: copies AMT words from a 32-bit source space into the CPU map.
// Define DMA_FILL_EN to enable fill mode (SRC_U bit 15 set writes SRC_L to every destination).
module dma_controller
  import dma_pkg::*;
#(
  parameter int AMT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic        memwrite,
  input  logic [15:0] writedata,
  output logic [15:0] regdata,
  output logic [31:0] src_addr,
  output logic        src_req,
  input  logic        src_ack,
  input  logic [15:0] src_data,
  output logic [15:0] dst_addr,
  output logic [15:0] dst_data,
  output logic        dst_we,
  input  logic        dst_grant,
  output logic        busy,
  output logic        done
);

  dma_state_e       state_q;
  logic [15:0]      srcL_q;
  logic [15:0]      srcU_q;
  logic [15:0]      dst_q;
  logic [15:0]      dstData_q;
  logic [15:0]      regdata_q;
  logic [AMT_W-1:0] amt_q;
  logic             srcReq_q;
  logic             dstWe_q;
  logic             busy_q;
  logic             done_q;

  logic             cpuWrite;
  logic             fillMode;
  logic [31:0]      srcInc_d;
  logic [AMT_W-1:0] amtWrite_d;

  assign cpuWrite   = en && memwrite && (state_q == ST_IDLE);
  assign srcInc_d   = {srcU_q, srcL_q} + 32'd1;
  assign amtWrite_d = writedata[AMT_W-1:0];

`ifdef DMA_FILL_EN
  assign fillMode = srcU_q[15];
`else
  assign fillMode = 1'b0;
`endif

  // Control FSM plus the programmable registers; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      srcL_q    <= '0;
      srcU_q    <= '0;
      dst_q     <= '0;
      dstData_q <= '0;
      amt_q     <= '0;
      srcReq_q  <= 1'b0;
      dstWe_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpuWrite) begin
            case (mode)
              REG_SRC_L: srcL_q <= writedata;
              REG_SRC_U: srcU_q <= writedata;
              REG_DST:   dst_q  <= writedata;
              REG_AMT: begin
                amt_q  <= amtWrite_d;
                busy_q <= 1'b1;
                if (amtWrite_d == '0) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else if (fillMode) begin
                  state_q   <= ST_WRITE;
                  dstWe_q   <= 1'b1;
                  dstData_q <= srcL_q;
                end else begin
                  state_q  <= ST_FETCH;
                  srcReq_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        ST_FETCH: begin
          if (src_ack) begin
            dstData_q <= src_data;
            srcReq_q  <= 1'b0;
            dstWe_q   <= 1'b1;
            state_q   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (dst_grant) begin
            dst_q <= dst_q + 16'd1;
            amt_q <= amt_q - AMT_W'(1);
            if (!fillMode) begin
              {srcU_q, srcL_q} <= srcInc_d;
            end
            // In fill mode the write strobe stays up, giving one word per cycle.
            if (amt_q == AMT_W'(1)) begin
              dstWe_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else if (!fillMode) begin
              dstWe_q  <= 1'b0;
              srcReq_q <= 1'b1;
              state_q  <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // CPU readback; the count is zero-extended and the bus reads 0 when not selected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      regdata_q <= '0;
    end else if (en) begin
      case (mode)
        REG_SRC_L: regdata_q <= srcL_q;
        REG_SRC_U: regdata_q <= srcU_q;
        REG_DST:   regdata_q <= dst_q;
        default:   regdata_q <= 16'(amt_q);
      endcase
    end else begin
      regdata_q <= '0;
    end
  end

  assign regdata  = regdata_q;
  assign src_addr = {srcU_q, srcL_q};
  assign src_req  = srcReq_q;
  assign dst_addr = dst_q;
  assign dst_data = dstData_q;
  assign dst_we   = dstWe_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed self-checking bench for dma_controller; a fill-mode scenario replaces the
// bit-15 copy scenario when DMA_FILL_EN is defined.
module tb_dma_controller;

  localparam logic [1:0] M_SRCL = 2'd0;
  localparam logic [1:0] M_SRCU = 2'd1;
  localparam logic [1:0] M_DST  = 2'd2;
  localparam logic [1:0] M_AMT  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        memwrite;
  logic [15:0] writedata;
  logic [15:0] regdata;
  logic [31:0] srcAddr;
  logic        srcReq;
  logic        srcAck;
  logic [15:0] srcData;
  logic [15:0] dstAddr;
  logic [15:0] dstData;
  logic        dstWe;
  logic        dstGrant;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int lastWriteCycle = 0;

  logic [15:0] wrAddr[$];
  logic [15:0] wrData[$];
  bit          srcReqSeen = 1'b0;
  bit          overlapSeen = 1'b0;

  always #5 clk = ~clk;

  dma_controller #(.AMT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .memwrite(memwrite),
    .writedata(writedata), .regdata(regdata), .src_addr(srcAddr),
    .src_req(srcReq), .src_ack(srcAck), .src_data(srcData),
    .dst_addr(dstAddr), .dst_data(dstData), .dst_we(dstWe),
    .dst_grant(dstGrant), .busy(busy), .done(done)
  );

  // Source memory model: each word's content is a fixed function of its address.
  function automatic logic [15:0] srcModel(input logic [31:0] a);
    return a[15:0] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  assign srcData = srcModel(srcAddr);

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Bus monitor, sampled late in each cycle so inputs and outputs are settled.
  always begin
    @(negedge clk);
    #3;
    if (dstWe && dstGrant) begin
      wrAddr.push_back(dstAddr);
      wrData.push_back(dstData);
    end
    if (srcReq) srcReqSeen = 1'b1;
    if (srcReq && dstWe) overlapSeen = 1'b1;
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] d);
    en = 1'b1; memwrite = 1'b1; mode = m; writedata = d;
    lastWriteCycle = cycleCnt;
    @(negedge clk);
    en = 1'b0; memwrite = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] m, output logic [15:0] v);
    en = 1'b1; memwrite = 1'b0; mode = m;
    @(negedge clk);
    v = regdata;
    en = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int lat, output bit ok);
    ok = 1'b0;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        lat = cycleCnt - lastWriteCycle;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    srcReqSeen = 1'b0;
    overlapSeen = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (regdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_regdata: got %h expected 0000", regdata); end
    checks++; if (srcReq !== 1'b0) begin errors++; $display("[TB] FAIL reset_src_req: got %b expected 0", srcReq); end
    checks++; if (dstWe !== 1'b0) begin errors++; $display("[TB] FAIL reset_dst_we: got %b expected 0", dstWe); end
    checks++; if (dstData !== 16'h0) begin errors++; $display("[TB] FAIL reset_dst_data: got %h expected 0000", dstData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (srcAddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_src_addr: got %h expected 00000000", srcAddr); end
    checks++; if (dstAddr !== 16'h0) begin errors++; $display("[TB] FAIL reset_dst_addr: got %h expected 0000", dstAddr); end
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(M_SRCL, 16'h1234);
    readReg(M_SRCL, v);
    checks++; if (v !== 16'h1234) begin errors++; $display("[TB] FAIL readback_srcl: got %h expected 1234", v); end
    @(negedge clk);
    checks++; if (regdata !== 16'h0) begin errors++; $display("[TB] FAIL readback_idle_zero: got %h expected 0000", regdata); end
  endtask

  task automatic test_copy();
    int lat; bit ok; logic [15:0] v;
    srcAck = 1'b1; dstGrant = 1'b1;
    applyStimulus(M_SRCU, 16'h0001);
    applyStimulus(M_SRCL, 16'h0000);
    applyStimulus(M_DST, 16'h2400);
    clearLog();
    applyStimulus(M_AMT, 16'd4);
    waitDone(50, lat, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL copy_done_timeout: got none expected done pulse"); end
    checks++; if (lat !== 9) begin errors++; $display("[TB] FAIL copy_latency: got %0d expected 9", lat); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL copy_done_width: got done=%b busy=%b expected 0 0", done, busy); end
    checks++; if (wrAddr.size() != 4) begin errors++; $display("[TB] FAIL copy_write_count: got %0d expected 4", wrAddr.size()); end
    for (int i = 0; i < 4 && i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 16'h2400 + 16'(i) || wrData[i] !== srcModel(32'h0001_0000 + 32'(i))) begin
        errors++;
        $display("[TB] FAIL copy_word%0d: got %h@%h expected %h@%h", i, wrData[i], wrAddr[i],
                 srcModel(32'h0001_0000 + 32'(i)), 16'h2400 + 16'(i));
      end
    end
    checks++; if (overlapSeen) begin errors++; $display("[TB] FAIL copy_req_we_overlap: got 1 expected 0"); end
    readReg(M_AMT, v);
    checks++; if (v !== 16'h0) begin errors++; $display("[TB] FAIL copy_count_after: got %h expected 0000", v); end
    readReg(M_SRCL, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("[TB] FAIL copy_srcl_after: got %h expected 0004", v); end
    readReg(M_DST, v);
    checks++; if (v !== 16'h2404) begin errors++; $display("[TB] FAIL copy_dst_after: got %h expected 2404", v); end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok;
    clearLog();
    applyStimulus(M_AMT, 16'd2);
    waitDone(50, lat, ok);
    checks++; if (!ok || lat !== 5) begin errors++; $display("[TB] FAIL chain_latency: got %0d expected 5", lat); end
    checks++; if (wrAddr.size() != 2) begin errors++; $display("[TB] FAIL chain_write_count: got %0d expected 2", wrAddr.size()); end
    for (int i = 0; i < 2 && i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 16'h2404 + 16'(i) || wrData[i] !== srcModel(32'h0001_0004 + 32'(i))) begin
        errors++;
        $display("[TB] FAIL chain_word%0d: got %h@%h expected %h@%h", i, wrData[i], wrAddr[i],
                 srcModel(32'h0001_0004 + 32'(i)), 16'h2404 + 16'(i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat; bit found; int hold; logic [15:0] v;
    applyStimulus(M_SRCU, 16'h0000);
    applyStimulus(M_SRCL, 16'h0100);
    applyStimulus(M_DST, 16'h1000);
    clearLog();
    hold = 0; found = 1'b0; lat = -1;
    applyStimulus(M_AMT, 16'd3);
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        found = 1'b1;
        lat = cycleCnt - lastWriteCycle;
        break;
      end
      if (dstWe && wrAddr.size() == 1 && hold < 3) begin
        dstGrant = 1'b0;
        en = (hold == 0); memwrite = (hold == 0); mode = M_DST; writedata = 16'hBEEF;
        checks++;
        if (dstAddr !== 16'h1001 || srcAddr !== 32'h0000_0101) begin
          errors++;
          $display("[TB] FAIL stall_addr_stable: got %h/%h expected 1001/00000101", dstAddr, srcAddr);
        end
        hold++;
      end else begin
        dstGrant = 1'b1; en = 1'b0; memwrite = 1'b0;
      end
      @(negedge clk);
    end
    dstGrant = 1'b1; en = 1'b0; memwrite = 1'b0;
    checks++; if (!found || lat !== 10) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 10", lat); end
    checks++; if (hold !== 3) begin errors++; $display("[TB] FAIL stall_we_held: got %0d expected 3", hold); end
    checks++; if (wrAddr.size() != 3) begin errors++; $display("[TB] FAIL stall_write_count: got %0d expected 3", wrAddr.size()); end
    for (int i = 0; i < 3 && i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 16'h1000 + 16'(i) || wrData[i] !== srcModel(32'h0000_0100 + 32'(i))) begin
        errors++;
        $display("[TB] FAIL stall_word%0d: got %h@%h expected %h@%h", i, wrData[i], wrAddr[i],
                 srcModel(32'h0000_0100 + 32'(i)), 16'h1000 + 16'(i));
      end
    end
    @(negedge clk);
    readReg(M_DST, v);
    checks++; if (v !== 16'h1003) begin errors++; $display("[TB] FAIL busy_write_ignored: got %h expected 1003", v); end
  endtask

  task automatic test_wrap();
    int lat; bit ok;
    applyStimulus(M_SRCU, 16'h0000);
    applyStimulus(M_SRCL, 16'hFFFF);
    applyStimulus(M_DST, 16'hFFFF);
    clearLog();
    applyStimulus(M_AMT, 16'd2);
    waitDone(50, lat, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_done_timeout: got none expected done pulse"); end
    checks++; if (wrAddr.size() != 2) begin errors++; $display("[TB] FAIL wrap_write_count: got %0d expected 2", wrAddr.size()); end
    if (wrAddr.size() == 2) begin
      checks++;
      if (wrAddr[0] !== 16'hFFFF || wrData[0] !== srcModel(32'h0000_FFFF)) begin
        errors++; $display("[TB] FAIL wrap_word0: got %h@%h expected %h@ffff", wrData[0], wrAddr[0], srcModel(32'h0000_FFFF));
      end
      checks++;
      if (wrAddr[1] !== 16'h0000 || wrData[1] !== srcModel(32'h0001_0000)) begin
        errors++; $display("[TB] FAIL wrap_word1: got %h@%h expected %h@0000", wrData[1], wrAddr[1], srcModel(32'h0001_0000));
      end
    end
    checks++; if (srcAddr !== 32'h0001_0001 || dstAddr !== 16'h0001) begin errors++; $display("[TB] FAIL wrap_final_addr: got %h/%h expected 00010001/0001", srcAddr, dstAddr); end
    @(negedge clk);
  endtask

  task automatic test_zero_amt();
    clearLog();
    applyStimulus(M_AMT, 16'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL zero_done_pulse: got done=%b busy=%b expected 1 1", done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_done_width: got done=%b busy=%b expected 0 0", done, busy); end
    @(negedge clk);
    checks++; if (srcReqSeen || wrAddr.size() != 0) begin errors++; $display("[TB] FAIL zero_no_traffic: got req=%b writes=%0d expected 0 0", srcReqSeen, wrAddr.size()); end
  endtask

  task automatic test_reset_mid();
    bit found; logic [15:0] v;
    applyStimulus(M_SRCU, 16'h0000);
    applyStimulus(M_SRCL, 16'h0200);
    applyStimulus(M_DST, 16'h3000);
    clearLog();
    found = 1'b0;
    applyStimulus(M_AMT, 16'd8);
    for (int i = 0; i < 40; i++) begin
      if (dstWe && wrAddr.size() == 2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL midreset_word3_timeout: got none expected word 3 write"); end
    rst = 1'b0; dstGrant = 1'b0;
    @(negedge clk);
    checks++;
    if (dstWe !== 1'b0 || srcReq !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dstData !== 16'h0 || regdata !== 16'h0) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got we=%b req=%b busy=%b done=%b data=%h reg=%h expected all 0",
               dstWe, srcReq, busy, done, dstData, regdata);
    end
    rst = 1'b1; dstGrant = 1'b1;
    srcReqSeen = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (wrAddr.size() != 2 || srcReqSeen) begin errors++; $display("[TB] FAIL midreset_no_more_traffic: got writes=%0d req=%b expected 2 0", wrAddr.size(), srcReqSeen); end
    readReg(M_AMT, v);
    checks++; if (v !== 16'h0) begin errors++; $display("[TB] FAIL midreset_count: got %h expected 0000", v); end
  endtask

`ifdef DMA_FILL_EN
  task automatic test_fill();
    int lat; bit ok;
    applyStimulus(M_SRCU, 16'h8000);
    applyStimulus(M_SRCL, 16'h00AA);
    applyStimulus(M_DST, 16'h4400);
    clearLog();
    applyStimulus(M_AMT, 16'd3);
    waitDone(50, lat, ok);
    checks++; if (!ok || lat !== 4) begin errors++; $display("[TB] FAIL fill_latency: got %0d expected 4", lat); end
    checks++; if (srcReqSeen) begin errors++; $display("[TB] FAIL fill_no_src_req: got 1 expected 0"); end
    checks++; if (wrAddr.size() != 3) begin errors++; $display("[TB] FAIL fill_write_count: got %0d expected 3", wrAddr.size()); end
    for (int i = 0; i < 3 && i < wrAddr.size(); i++) begin
      checks++;
      if (wrAddr[i] !== 16'h4400 + 16'(i) || wrData[i] !== 16'h00AA) begin
        errors++; $display("[TB] FAIL fill_word%0d: got %h@%h expected 00aa@%h", i, wrData[i], wrAddr[i], 16'h4400 + 16'(i));
      end
    end
    checks++; if (srcAddr !== 32'h8000_00AA) begin errors++; $display("[TB] FAIL fill_src_static: got %h expected 800000aa", srcAddr); end
    @(negedge clk);
  endtask
`else
  task automatic test_bit15_copy();
    int lat; bit ok;
    applyStimulus(M_SRCU, 16'h8000);
    applyStimulus(M_SRCL, 16'h0010);
    applyStimulus(M_DST, 16'h0050);
    clearLog();
    applyStimulus(M_AMT, 16'd1);
    waitDone(50, lat, ok);
    checks++; if (!ok || lat !== 3) begin errors++; $display("[TB] FAIL bit15_latency: got %0d expected 3", lat); end
    checks++; if (!srcReqSeen) begin errors++; $display("[TB] FAIL bit15_src_req: got 0 expected 1"); end
    checks++;
    if (wrAddr.size() != 1 || wrData[0] !== srcModel(32'h8000_0010) || wrAddr[0] !== 16'h0050) begin
      errors++; $display("[TB] FAIL bit15_word: got %0d writes expected 1 write of %h@0050", wrAddr.size(), srcModel(32'h8000_0010));
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b0; en = 1'b0; memwrite = 1'b0; mode = 2'd0; writedata = 16'h0;
    srcAck = 1'b1; dstGrant = 1'b1;
    @(negedge clk);
    test_reset();
    test_copy();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_zero_amt();
    test_reset_mid();
`ifdef DMA_FILL_EN
    test_fill();
`else
    test_bit15_copy();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
